fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch front end that produces the fetch-side inputs of the decode stage: instruction word, its PC and PC+4. It owns the fetch PC, issues in-order requests to a variable-latency instruction memory with a request/grant and response-valid handshake, and buffers returned instructions in a small FIFO. Decode back-pressure (stall) and control-flow redirects from execute are handled without dropping or duplicating instructions.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 2, FIFO entries and maximum in-flight requests combined (power of two, ≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  request valid
- imem_addr  out  32  request address (word aligned)
- imem_gnt  in  1  request accepted this cycle (meaningful only with imem_req)
- imem_rvalid  in  1  response valid, in request order, ≥1 cycle after grant
- imem_rdata  in  32  response instruction word
- stallD  in  1  decode cannot accept this cycle
- redirect  in  1  taken branch/jump; flush and refetch
- redirect_pc  in  32  new fetch address
- instrD  out  32  instruction to decode
- pcF  out  32  PC of instrD
- pcplusfourF  out  32  pcF + 4 (mod 2^32)
- validD  out  1  instrD/pcF/pcplusfourF valid

## Operation
- State: reqpc (next address to request), outstanding counter (0..DEPTH), discard counter (0..DEPTH), pending-PC queue (DEPTH), instruction FIFO of {instr, pc} (DEPTH).
- Request: imem_req = !redirect && (occupancy + outstanding − pop) < DEPTH, where pop = validD && !stallD. imem_addr = reqpc.
- Grant (imem_req && imem_gnt): push reqpc into pending queue, reqpc += 4 (wraps), outstanding += 1.
- Response (imem_rvalid): pop pending queue, outstanding −= 1. If discard > 0: drop, discard −= 1. Else push {imem_rdata, pc} into FIFO. imem_rvalid with outstanding = 0 is ignored.
- Output: validD = FIFO non-empty; instrD/pcF = FIFO head; pcplusfourF = head pc + 4. FIFO empty: instrD = 32'h0000_0013 (NOP), pcF = 0, pcplusfourF = 4.
- Pop: validD && !stallD advances head. Push and pop in the same cycle allowed at any occupancy.
- Redirect: FIFO flushed; reqpc ← {redirect_pc[31:2], 2'b00}; discard ← outstanding after this cycle's response (responses arriving in the redirect cycle are dropped); imem_req forced low that cycle. Redirect overrides stallD and pop.
- No overflow possible: credit rule bounds occupancy + outstanding ≤ DEPTH.

## Timing
- Reset (async assert, sync-free release): reqpc = RESET_PC, counters 0, FIFO empty; outputs imem_req 0 while rst high, imem_addr = RESET_PC, validD 0, instrD 32'h0000_0013, pcF 0, pcplusfourF 4.
- First cycle after rst release: imem_req = 1, imem_addr = RESET_PC.
- Latency: grant in cycle G, earliest rvalid G+1, validD with that instruction at G+2.
- Throughput: DEPTH = 2, 1-cycle memory, gnt always 1, stallD 0 → one instruction per cycle sustained.
- Redirect in cycle R: validD = 0 at R+1; imem_req with redirect_pc at R+1; first post-redirect instruction at R+3 with 1-cycle memory (later if discards pending).
- Reset mid-operation: all in-flight requests forgotten; environment must not return responses for pre-reset grants.
- imem_addr may change only when no grant occurred (held while imem_req && !imem_gnt).

## Test plan
- Reset: rst pulse mid-cycle → validD 0, instrD 0x00000013, imem_addr 0x00000000 immediately; after release, req at 0x0, then 0x4, 0x8 each cycle.
- Streaming: 1-cycle memory returning addr-based words, gnt=1 → validD continuous from cycle 3, pcF 0,4,8,…, pcplusfourF = pcF+4, no gaps.
- Stall: stallD high 5 cycles mid-stream → instrD/pcF frozen, imem_req drops once occupancy+outstanding = 2, resumes without loss or duplicate.
- Redirect with in-flight: 3-cycle memory, 2 outstanding, redirect_pc 0x0000_0103 → both stale responses dropped, next validD shows pcF 0x0000_0100.
- Grant stalls: imem_gnt low 4 cycles → imem_addr held constant, no extra pending entries, sequence intact.
- Simultaneous: redirect with rvalid and stallD same cycle → response dropped, FIFO empty next cycle, fetch restarts at redirect_pc; wrap: redirect_pc 0xFFFF_FFFC → next pcplusfourF 0x0000_0000, next pcF 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order requests to a
// variable-latency instruction memory and buffers returned words for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stallD,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instrD,
    output logic [31:0] pcF,
    output logic [31:0] pcplusfourF,
    output logic        validD
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   reqPc_q, reqPc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] pendRd_q, pendRd_d, pendWr_q, pendWr_d;
    logic [AW-1:0] fifoRd_q, fifoRd_d, fifoWr_q, fifoWr_d;

    logic [31:0]   pendPc_q    [DEPTH];
    logic [31:0]   fifoInstr_q [DEPTH];
    logic [31:0]   fifoPc_q    [DEPTH];

    logic          pop;
    logic          grant;
    logic          resp;
    logic          keep;
    logic [CW:0]   inUse;

    assign validD = (count_q != '0);
    assign pop    = validD && !stallD && !redirect;
    assign resp   = imem_rvalid && (outstanding_q != '0);
    assign keep   = resp && (discard_q == '0) && !redirect;

    // Credit check: buffered plus in-flight words never exceed DEPTH, so the FIFO cannot overflow.
    assign inUse     = {1'b0, count_q} + {1'b0, outstanding_q} - {{CW{1'b0}}, pop};
    assign imem_req  = !rst && !redirect && (inUse < DEPTH_W);
    assign imem_addr = reqPc_q;
    assign grant     = imem_req && imem_gnt;

    assign instrD      = validD ? fifoInstr_q[fifoRd_q] : NOP;
    assign pcF         = validD ? fifoPc_q[fifoRd_q] : 32'h0000_0000;
    assign pcplusfourF = pcF + 32'd4;

    always_comb begin
        reqPc_d       = reqPc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        pendRd_d      = pendRd_q;
        pendWr_d      = pendWr_q;
        fifoRd_d      = fifoRd_q;
        fifoWr_d      = fifoWr_q;

        if (grant) begin
            reqPc_d       = reqPc_q + 32'd4;
            outstanding_d = outstanding_d + CW'(1);
            pendWr_d      = pendWr_q + AW'(1);
        end
        if (resp) begin
            outstanding_d = outstanding_d - CW'(1);
            pendRd_d      = pendRd_q + AW'(1);
            if (discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end
        if (keep) begin
            count_d  = count_d + CW'(1);
            fifoWr_d = fifoWr_q + AW'(1);
        end
        if (pop) begin
            count_d  = count_d - CW'(1);
            fifoRd_d = fifoRd_q + AW'(1);
        end

        // Every request still in flight after this cycle returns stale data and must be dropped.
        if (redirect) begin
            reqPc_d   = redirect_pc & 32'hFFFF_FFFC;
            discard_d = outstanding_q - (resp ? CW'(1) : CW'(0));
            count_d   = '0;
            fifoRd_d  = '0;
            fifoWr_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reqPc_q       <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            pendRd_q      <= '0;
            pendWr_q      <= '0;
            fifoRd_q      <= '0;
            fifoWr_q      <= '0;
        end else begin
            reqPc_q       <= reqPc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            pendRd_q      <= pendRd_d;
            pendWr_q      <= pendWr_d;
            fifoRd_q      <= fifoRd_d;
            fifoWr_q      <= fifoWr_d;
        end
    end

    // Storage arrays need no reset; the pointers and counters above decide what is live.
    always_ff @(posedge clk) begin
        if (grant) begin
            pendPc_q[pendWr_q] <= reqPc_q;
        end
        if (keep) begin
            fifoInstr_q[fifoWr_q] <= imem_rdata;
            fifoPc_q[fifoWr_q]    <= pendPc_q[pendRd_q];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a fixed-latency memory model answers requests
// with address-derived words and each scenario task checks hand-computed values.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'h1357_9BDF;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stallD = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instrD;
    logic [31:0] pcF;
    logic [31:0] pcplusfourF;
    logic        validD;

    int          checks = 0;
    int          failures = 0;
    int          cycleNum = 0;
    int          memLat = 1;
    logic        gntEn = 1'b1;
    logic        lastReq;
    logic [31:0] lastAddr;
    logic [31:0] memAddrQ [$];
    int          memDueQ [$];

    fetch_unit dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .stallD(stallD),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instrD(instrD),
        .pcF(pcF),
        .pcplusfourF(pcplusfourF),
        .validD(validD)
    );

    always #5 clk = ~clk;

    // One clock cycle: drive inputs, answer from the memory model, sample the request, advance.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
        stallD      = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = gntEn;
        if (memDueQ.size() > 0 && memDueQ[0] == cycleNum) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memAddrQ[0] ^ KEY;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_0000;
        end
        #1;
        lastReq  = imem_req;
        lastAddr = imem_addr;
        @(posedge clk);
        if (imem_rvalid) begin
            void'(memAddrQ.pop_front());
            void'(memDueQ.pop_front());
        end
        if (lastReq && imem_gnt) begin
            memAddrQ.push_back(lastAddr);
            memDueQ.push_back(cycleNum + memLat);
        end
        cycleNum++;
        #1;
    endtask

    task automatic doReset();
        rst         = 1'b1;
        stallD      = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        gntEn       = 1'b1;
        memAddrQ.delete();
        memDueQ.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        cycleNum = 0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (validD !== 1'b0 || instrD !== NOP || pcF !== 32'h0 || pcplusfourF !== 32'h4) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%b instr=%h pc=%h pc4=%h expected 0 00000013 0 4",
                     validD, instrD, pcF, pcplusfourF);
        end
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_req: got req=%b addr=%h expected 0 00000000", imem_req, imem_addr);
        end
        doReset();
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL first_req: got req=%b addr=%h expected 1 00000000", imem_req, imem_addr);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h4) begin
            failures++;
            $display("[TB] FAIL second_addr: got %h expected 00000004", imem_addr);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (imem_addr !== 32'h8 || lastAddr !== 32'h4) begin
            failures++;
            $display("[TB] FAIL third_addr: got %h last %h expected 00000008 00000004", imem_addr, lastAddr);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (validD !== 1'b1 || pcF !== 32'h4) begin
            failures++;
            $display("[TB] FAIL pre_midreset: got valid=%b pc=%h expected 1 00000004", validD, pcF);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (validD !== 1'b0 || instrD !== NOP || imem_addr !== 32'h0 || imem_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_reset: got valid=%b instr=%h addr=%h req=%b expected 0 00000013 0 0",
                     validD, instrD, imem_addr, imem_req);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] expPc;
        memLat = 1;
        doReset();
        for (int k = 1; k <= 10; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (k >= 2) begin
                expPc = 32'(4 * (k - 2));
                checks++;
                if (validD !== 1'b1 || pcF !== expPc || pcplusfourF !== expPc + 32'd4 ||
                    instrD !== (expPc ^ KEY)) begin
                    failures++;
                    $display("[TB] FAIL stream_%0d: got valid=%b pc=%h pc4=%h instr=%h expected pc=%h",
                             k, validD, pcF, pcplusfourF, instrD, expPc);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] expPc;
        memLat = 1;
        doReset();
        for (int k = 1; k <= 4; k++) tick(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0, 32'h0);
            checks++;
            if (validD !== 1'b1 || pcF !== 32'h8 || instrD !== (32'h8 ^ KEY) ||
                imem_req !== 1'b0 || imem_addr !== 32'h10) begin
                failures++;
                $display("[TB] FAIL stall_%0d: got valid=%b pc=%h req=%b addr=%h expected 1 00000008 0 00000010",
                         k, validD, pcF, imem_req, imem_addr);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            expPc = 32'(12 + 4 * k);
            checks++;
            if (validD !== 1'b1 || pcF !== expPc || instrD !== (expPc ^ KEY)) begin
                failures++;
                $display("[TB] FAIL stall_resume_%0d: got valid=%b pc=%h instr=%h expected pc=%h",
                         k, validD, pcF, instrD, expPc);
            end
        end
    endtask

    task automatic test_redirect_inflight();
        memLat = 3;
        doReset();
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b1, 32'h0000_0103);
        checks++;
        if (validD !== 1'b0 || imem_addr !== 32'h100) begin
            failures++;
            $display("[TB] FAIL redir_addr: got valid=%b addr=%h expected 0 00000100", validD, imem_addr);
        end
        for (int k = 4; k <= 7; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            checks++;
            if (validD !== 1'b0) begin
                failures++;
                $display("[TB] FAIL redir_drop_%0d: got valid=%b pc=%h expected valid 0", k, validD, pcF);
            end
            if (k == 5) begin
                checks++;
                if (lastReq !== 1'b1 || lastAddr !== 32'h100) begin
                    failures++;
                    $display("[TB] FAIL redir_req: got req=%b addr=%h expected 1 00000100", lastReq, lastAddr);
                end
            end
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (validD !== 1'b1 || pcF !== 32'h100 || instrD !== (32'h100 ^ KEY)) begin
            failures++;
            $display("[TB] FAIL redir_first: got valid=%b pc=%h instr=%h expected pc=00000100",
                     validD, pcF, instrD);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (validD !== 1'b1 || pcF !== 32'h104) begin
            failures++;
            $display("[TB] FAIL redir_second: got valid=%b pc=%h expected pc=00000104", validD, pcF);
        end
    endtask

    task automatic test_grant_stall();
        memLat = 1;
        doReset();
        for (int k = 1; k <= 3; k++) tick(1'b0, 1'b0, 32'h0);
        gntEn = 1'b0;
        for (int k = 4; k <= 7; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            checks++;
            if (lastReq !== 1'b1 || imem_addr !== 32'hC) begin
                failures++;
                $display("[TB] FAIL gnt_hold_%0d: got req=%b addr=%h expected 1 0000000c", k, lastReq, imem_addr);
            end
        end
        gntEn = 1'b1;
        tick(1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (validD !== 1'b1 || pcF !== 32'hC || instrD !== (32'hC ^ KEY)) begin
            failures++;
            $display("[TB] FAIL gnt_resume: got valid=%b pc=%h instr=%h expected pc=0000000c", validD, pcF, instrD);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (validD !== 1'b1 || pcF !== 32'h10) begin
            failures++;
            $display("[TB] FAIL gnt_next: got valid=%b pc=%h expected pc=00000010", validD, pcF);
        end
    endtask

    task automatic test_simultaneous();
        memLat = 1;
        doReset();
        for (int k = 1; k <= 3; k++) tick(1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'hFFFF_FFFC);
        checks++;
        if (validD !== 1'b0 || instrD !== NOP || pcF !== 32'h0 || pcplusfourF !== 32'h4 ||
            imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("[TB] FAIL simul_flush: got valid=%b instr=%h pc=%h pc4=%h addr=%h expected 0 00000013 0 4 fffffffc",
                     validD, instrD, pcF, pcplusfourF, imem_addr);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (lastReq !== 1'b1 || lastAddr !== 32'hFFFF_FFFC || validD !== 1'b0) begin
            failures++;
            $display("[TB] FAIL simul_req: got req=%b addr=%h valid=%b expected 1 fffffffc 0",
                     lastReq, lastAddr, validD);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (validD !== 1'b1 || pcF !== 32'hFFFF_FFFC || pcplusfourF !== 32'h0) begin
            failures++;
            $display("[TB] FAIL wrap_last: got valid=%b pc=%h pc4=%h expected 1 fffffffc 00000000",
                     validD, pcF, pcplusfourF);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if (validD !== 1'b1 || pcF !== 32'h0 || pcplusfourF !== 32'h4 || instrD !== KEY) begin
            failures++;
            $display("[TB] FAIL wrap_first: got valid=%b pc=%h pc4=%h instr=%h expected 1 0 4 %h",
                     validD, pcF, pcplusfourF, instrD, KEY);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_redirect_inflight();
        test_grant_stall();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
